// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out stream bundle for conv_window_gen.
//   i_clear  - synchronous frame restart
//   i_valid  - input pixel valid        i_data   - input pixel (DATA_W, signed)
//   o_ready  - input ready              o_valid  - output window valid
//   o_window - packed 3x3 window, d(k) at [k*DATA_W +: DATA_W]
//   i_ready  - downstream ready
//   o_last   - final window of a frame (present only when CONV_LAST_EN is defined)
// Modports: master = pixel producer / window consumer, slave = conv_window_gen.
interface conv_window_gen_if #(
    parameter int unsigned DATA_W = 10
);
    logic                  i_clear;
    logic                  i_valid;
    logic [DATA_W-1:0]     i_data;
    logic                  o_ready;
    logic                  o_valid;
    logic [9*DATA_W-1:0]   o_window;
    logic                  i_ready;
`ifdef CONV_LAST_EN
    logic                  o_last;

    modport master (
        output i_clear, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_window, o_last
    );
    modport slave (
        input  i_clear, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_window, o_last
    );
`else
    modport master (
        output i_clear, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_window
    );
    modport slave (
        input  i_clear, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_window
    );
`endif
endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator feeding the conv engine's window ports.
// Takes a raster-order pixel stream and emits packed windows {d8..d0}, d0 = top-left,
// row-major, d8 = bottom-right. One window per accepted pixel with row >= 2 and col >= 2.
// Ports:
//   i_clk - clock (rising edge)
//   i_rst - asynchronous reset, active-high
//   bus   - conv_window_gen_if.slave (i_clear, i_valid, i_data, o_ready, o_valid,
//           o_window, i_ready, and o_last when enabled)
// Optional feature: define CONV_LAST_EN to add o_last, flagging the final window of a frame.
module conv_window_gen #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    conv_window_gen_if.slave bus
);
    localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic                  valid_q, valid_d;
    logic [9*DATA_W-1:0]   window_q, window_d;
`ifdef CONV_LAST_EN
    logic                  last_q, last_d;
`endif

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
    logic [DATA_W-1:0]     lb1_q [IMG_W];
    logic [DATA_W-1:0]     lb2_q [IMG_W];
    // Two previous columns of the window; the third (newest) column is formed
    // combinationally from the line-buffer reads and the incoming pixel.
    logic [DATA_W-1:0]     top_q [2];
    logic [DATA_W-1:0]     mid_q [2];
    logic [DATA_W-1:0]     bot_q [2];

    logic                  accept;
    logic                  win_done;
    logic                  col_last;
    logic                  row_last;
    logic [DATA_W-1:0]     lb1_rd;
    logic [DATA_W-1:0]     lb2_rd;

    assign bus.o_ready  = ~valid_q | bus.i_ready;
    assign bus.o_valid  = valid_q;
    assign bus.o_window = window_q;
`ifdef CONV_LAST_EN
    assign bus.o_last   = last_q;
`endif

    // Clear wins over a simultaneous accept: nothing is shifted in.
    assign accept   = bus.i_valid & bus.o_ready & ~bus.i_clear;
    assign col_last = (col_q == ColW'(IMG_W - 1));
    assign row_last = (row_q == RowW'(IMG_H - 1));
    assign win_done = accept & (row_q >= RowW'(2)) & (col_q >= ColW'(2));
    assign lb1_rd   = lb1_q[col_q];
    assign lb2_rd   = lb2_q[col_q];

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        valid_d  = valid_q;
        window_d = window_q;
`ifdef CONV_LAST_EN
        last_d   = last_q;
`endif
        if (bus.i_clear) begin
            col_d   = '0;
            row_d   = '0;
            valid_d = 1'b0;
`ifdef CONV_LAST_EN
            last_d  = 1'b0;
`endif
        end else begin
            if (valid_q && bus.i_ready) begin
                valid_d = 1'b0;
`ifdef CONV_LAST_EN
                last_d  = 1'b0;
`endif
            end
            if (accept) begin
                if (col_last) begin
                    col_d = '0;
                    row_d = row_last ? '0 : row_q + RowW'(1);
                end else begin
                    col_d = col_q + ColW'(1);
                end
            end
            // A new window overrides the transfer-driven drop of o_valid.
            if (win_done) begin
                valid_d  = 1'b1;
                window_d = {bus.i_data, bot_q[1], bot_q[0],
                            lb1_rd,     mid_q[1], mid_q[0],
                            lb2_rd,     top_q[1], top_q[0]};
`ifdef CONV_LAST_EN
                last_d   = row_last & col_last;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q    <= '0;
            row_q    <= '0;
            valid_q  <= 1'b0;
            window_q <= '0;
`ifdef CONV_LAST_EN
            last_q   <= 1'b0;
`endif
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            valid_q  <= valid_d;
            window_q <= window_d;
`ifdef CONV_LAST_EN
            last_q   <= last_d;
`endif
        end
    end

    // Datapath storage carries no reset; its contents before the first rows are don't-care.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            top_q[0]     <= top_q[1];
            top_q[1]     <= lb2_rd;
            mid_q[0]     <= mid_q[1];
            mid_q[1]     <= lb1_rd;
            bot_q[0]     <= bot_q[1];
            bot_q[1]     <= bus.i_data;
            lb2_q[col_q] <= lb1_rd;
            lb1_q[col_q] <= bus.i_data;
        end
    end
endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
    localparam int unsigned DW = 10;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    logic clk;
    logic rst;

    conv_window_gen_if #(.DATA_W(DW)) bus ();

    conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: image of the current frame plus the expected output register.
    logic [DW-1:0]   img [H][W];
    int              pos;
    logic            exp_valid;
    logic [9*DW-1:0] exp_win;
    logic            exp_last;
    int              n_acc;
    int              n_xfer;
    logic            last_acc;
    logic [9*DW-1:0] win_log [$];
    logic            last_log [$];

    task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack_img(input int r, input int c);
        logic [9*DW-1:0] res;
        for (int k = 0; k < 9; k++) res[k*DW +: DW] = img[r - 2 + k / 3][c - 2 + k % 3];
        return res;
    endfunction

    function automatic logic [9*DW-1:0] w9(input int v [9]);
        logic [9*DW-1:0] res;
        for (int k = 0; k < 9; k++) res[k*DW +: DW] = DW'(v[k]);
        return res;
    endfunction

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        pos       = 0;
    endtask

    // Called at a negedge: drive inputs, check outputs, predict the next edge, advance.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        logic acc;
        logic xfer;
        int   r;
        int   c;
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_ready = rdy;
        bus.i_clear = clr;
        #1;
        chk("o_valid", bus.o_valid, exp_valid);
        chk("o_ready", bus.o_ready, !exp_valid || rdy);
        if (exp_valid) begin
            chk("o_window", bus.o_window, exp_win);
`ifdef CONV_LAST_EN
            chk("o_last", bus.o_last, exp_last);
`endif
        end
        acc  = v && (!exp_valid || rdy) && !clr;
        xfer = exp_valid && rdy;
        if (xfer) begin
            n_xfer++;
            win_log.push_back(bus.o_window);
`ifdef CONV_LAST_EN
            last_log.push_back(bus.o_last);
`else
            last_log.push_back(1'b0);
`endif
        end
        if (clr) begin
            model_reset();
        end else begin
            if (xfer) begin
                exp_valid = 1'b0;
                exp_last  = 1'b0;
            end
            if (acc) begin
                n_acc++;
                r = pos / W;
                c = pos % W;
                img[r][c] = d;
                if (r >= 2 && c >= 2) begin
                    exp_valid = 1'b1;
                    exp_win   = pack_img(r, c);
                    exp_last  = (pos == W * H - 1);
                end
                pos = (pos + 1) % (W * H);
            end
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic stream(input int base);
        for (int i = 0; i < W * H; i++) step(1'b1, DW'(base + i), 1'b1, 1'b0);
    endtask

    task automatic clear_logs();
        win_log.delete();
        last_log.delete();
        n_xfer = 0;
    endtask

    initial begin
        int v [9];
        int p;
        int stall_left;
        bit stalled;
        int budget;
        n_acc = 0;
        n_xfer = 0;
        model_reset();
        exp_win = '0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_ready = 1'b1;
        bus.i_clear = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_o_valid", bus.o_valid, 1'b0);
        chk("rst_o_window", bus.o_window, '0);
`ifdef CONV_LAST_EN
        chk("rst_o_last", bus.o_last, 1'b0);
`endif
        rst = 1'b0;
        #1;
        chk("rst_o_ready", bus.o_ready, 1'b1);
        @(negedge clk);

        // Continuous stream 0..15.
        clear_logs();
        stream(0);
        drain(2);
        chk("s1_count", 32'(n_xfer), 32'd4);
        v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("s1_win0", win_log[0], w9(v));
        v = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        chk("s1_win1", win_log[1], w9(v));
        v = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        chk("s1_win3", win_log[3], w9(v));
`ifdef CONV_LAST_EN
        chk("s6_last", {28'd0, last_log[0], last_log[1], last_log[2], last_log[3]}, 32'b0001);
`endif

        // Backpressure: i_ready low for 5 cycles starting at the first o_valid.
        clear_logs();
        p = 0;
        stall_left = 0;
        stalled = 1'b0;
        budget = 0;
        while (p < W * H && budget < 200) begin
            if (exp_valid && !stalled) begin
                stalled = 1'b1;
                stall_left = 5;
            end
            step(1'b1, DW'(p), stall_left == 0, 1'b0);
            if (last_acc) p++;
            if (stall_left > 0) stall_left--;
            budget++;
        end
        drain(2);
        chk("s2_all_accepted", 32'(p), 32'(W * H));
        chk("s2_count", 32'(n_xfer), 32'd4);
        v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("s2_win0", win_log[0], w9(v));
        v = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        chk("s2_win3", win_log[3], w9(v));

        // Signed data passes bit-exact.
        clear_logs();
        for (int i = 0; i < W * H; i++) step(1'b1, 10'h39C, 1'b1, 1'b0);
        drain(2);
        chk("s3_count", 32'(n_xfer), 32'd4);
        for (int i = 0; i < 4; i++) chk("s3_signed", win_log[i], {9{10'h39C}});

        // Async reset after pixel 9.
        for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("s4_rst_valid", bus.o_valid, 1'b0);
        chk("s4_rst_window", bus.o_window, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_logs();
        stream(0);
        drain(2);
        chk("s4_count", 32'(n_xfer), 32'd4);
        v = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("s4_win0", win_log[0], w9(v));

        // Back-to-back frames, no gap.
        clear_logs();
        stream(0);
        stream(100);
        drain(2);
        chk("s5_count", 32'(n_xfer), 32'd8);
        v = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        chk("s5_f2_win0", win_log[4], w9(v));

        // Clear mid-frame wins over a simultaneous accept.
        for (int i = 0; i < 7; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
        step(1'b1, DW'(7), 1'b1, 1'b1);
        clear_logs();
        stream(200);
        drain(2);
        chk("clr_count", 32'(n_xfer), 32'd4);
        v = '{200, 201, 202, 204, 205, 206, 208, 209, 210};
        chk("clr_win0", win_log[0], w9(v));

        // Random data with random valid/ready gaps over three frames.
        clear_logs();
        n_acc = 0;
        budget = 0;
        while (n_acc < 3 * W * H && budget < 2000) begin
            step($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 7, 1'b0);
            budget++;
        end
        drain(3);
        chk("rnd_accepted", 32'(n_acc), 32'(3 * W * H));
        chk("rnd_count", 32'(n_xfer), 32'd12);
`ifdef CONV_LAST_EN
        chk("rnd_last", {29'd0, last_log[3], last_log[7], last_log[11]}, 32'b111);
        chk("rnd_not_last", {29'd0, last_log[0], last_log[5], last_log[10]}, 32'b000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
